// File: rtl/add_arb.sv
// Round-robin arbiter that time-shares one 8-bit ripple adder among NUM_REQ clients.
// Latency: response valid 2 cycles after accept; rsp_ready low freezes the response and blocks new grants.

module adder (
   input  logic [7:0] A,
   input  logic [7:0] B,
   output logic [7:0] Result
);
   assign Result = A + B;
endmodule

module add_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_a,
   input  logic [8*NUM_REQ-1:0]   req_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [7:0]             rsp_sum,
   output logic                   rsp_carry,
   output logic                   busy
);
   localparam int CW = ID_W + 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] id_q;
   logic [7:0]      op_a_q, op_b_q;
   logic            rsp_valid_q;
   logic [7:0]      rsp_sum_q;
   logic            rsp_carry_q;
   logic [ID_W-1:0] rsp_id_q;

   logic            win_vld;
   logic [ID_W-1:0] win_id;
   logic [CW-1:0]   cand;
   logic [CW-1:0]   ptr_inc;
   logic [7:0]      win_a, win_b;
   logic            accept;
   logic [7:0]      adder_res;
   logic            carry;

   // Search upward from the pointer; ptr < NUM_REQ keeps cand below 2*NUM_REQ, so one wrap suffices.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = CW'(ptr_q) + CW'(k);
         if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
         if (!win_vld && req_valid[cand[ID_W-1:0]]) begin
            win_vld = 1'b1;
            win_id  = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      win_a = '0;
      win_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == ID_W'(i)) begin
            win_a = req_a[8*i +: 8];
            win_b = req_b[8*i +: 8];
         end
      end
      ptr_inc = CW'(win_id) + CW'(1);
      if (ptr_inc == CW'(NUM_REQ)) ptr_inc = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      accept    = 1'b0;
      ptr_d     = ptr_q;
      case (state_q)
         IDLE: begin
            if (win_vld && rst_n) begin
               req_ready = NUM_REQ'(1) << win_id;
               accept    = 1'b1;
               ptr_d     = ptr_inc[ID_W-1:0];
               state_d   = EXEC;
            end
         end
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   adder u_adder (
      .A      (op_a_q),
      .B      (op_b_q),
      .Result (adder_res)
   );

   // Ninth bit of the widened sum; the adder itself exposes no carry.
   assign carry = |(({1'b0, op_a_q} + {1'b0, op_b_q}) >> 8);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         id_q        <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_carry_q <= 1'b0;
         rsp_id_q    <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (accept) begin
            op_a_q <= win_a;
            op_b_q <= win_b;
            id_q   <= win_id;
         end
         if (state_q == EXEC) begin
            rsp_sum_q   <= adder_res;
            rsp_carry_q <= carry;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
         end else if (state_q == RESP && rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add_arb.sv
// Directed and randomized checks of add_arb: reset, arithmetic edges, rotation, stalls, aborts.
module tb_add_arb;
   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [8*N-1:0]  req_a, req_b;
   logic [N-1:0]    req_ready;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [7:0]      rsp_sum;
   logic            rsp_carry;
   logic            busy;

   int n_chk  = 0;
   int n_pass = 0;

   add_arb #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b);
      req_valid[r]     = 1'b1;
      req_a[8*r +: 8]  = a;
      req_b[8*r +: 8]  = b;
   endtask

   // Single-client operation with rsp_ready held high; expected sum/carry hand-computed by caller.
   task automatic run_op(input string tag, input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic ec);
      int n;
      rsp_ready = 1'b1;
      req_valid = '0;
      set_req(r, a, b);
      #1;
      n = 0;
      while (!req_ready[r] && n < 20) begin
         next_cyc();
         n++;
      end
      chk({tag, "_grant"}, 32'(req_ready), 32'(1) << r);
      next_cyc();
      req_valid = '0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      next_cyc();
      chk({tag, "_vld"},   32'(rsp_valid), 32'd1);
      chk({tag, "_id"},    32'(rsp_id),    32'(r));
      chk({tag, "_sum"},   32'(rsp_sum),   32'(es));
      chk({tag, "_carry"}, 32'(rsp_carry), 32'(ec));
      next_cyc();
      chk({tag, "_vld_1cyc"}, 32'(rsp_valid), 32'd0);
   endtask

   task automatic drain();
      int n;
      req_valid = '0;
      rsp_ready = 1'b1;
      n = 0;
      while (busy && n < 20) begin
         next_cyc();
         n++;
      end
      chk("drain_idle", 32'(busy), 32'd0);
   endtask

   initial begin : main
      int viol, n;
      int gid[$];
      int gcyc[$];
      logic        pend [N];
      logic [7:0]  pa [N];
      logic [7:0]  pb [N];
      int          q_id[$];
      int          q_s9[$];
      logic [N-1:0] acc;
      int          e_id, e_s9;

      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld",   32'(rsp_valid), 32'd0);
      chk("rst_sum",   32'(rsp_sum),   32'd0);
      chk("rst_carry", 32'(rsp_carry), 32'd0);
      chk("rst_id",    32'(rsp_id),    32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      set_req(0, 8'h12, 8'h34);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      rst_n = 1'b1;
      next_cyc();

      run_op("basic",  0, 8'h12, 8'h34, 8'h46, 1'b0);
      run_op("ovf_ff", 2, 8'hFF, 8'h01, 8'h00, 1'b1);
      run_op("ovf_80", 1, 8'h80, 8'h80, 8'h00, 1'b1);
      run_op("zero",   3, 8'h00, 8'h00, 8'h00, 1'b0);
      run_op("mid",    2, 8'hA5, 8'h5A, 8'hFF, 1'b0);

      // Backpressure: hold rsp_ready low while requester 3 waits.
      rsp_ready = 1'b0;
      req_valid = '0;
      set_req(1, 8'h55, 8'h66);
      #1;
      chk("bp_grant1", 32'(req_ready), 32'h2);
      next_cyc();
      req_valid = '0;
      next_cyc();
      chk("bp_vld", 32'(rsp_valid), 32'd1);
      chk("bp_sum", 32'(rsp_sum),   32'hBB);
      set_req(3, 8'h01, 8'h02);
      viol = 0;
      repeat (10) begin
         next_cyc();
         if (rsp_sum !== 8'hBB || rsp_id !== 2'd1 || rsp_carry !== 1'b0 ||
             rsp_valid !== 1'b1 || req_ready !== '0) viol++;
      end
      chk("bp_stable", 32'(viol), 32'd0);
      rsp_ready = 1'b1;
      #1;
      chk("bp_no_early_grant", 32'(req_ready), 32'd0);
      next_cyc();
      chk("bp_vld_clr", 32'(rsp_valid), 32'd0);
      chk("bp_grant3",  32'(req_ready), 32'h8);
      next_cyc();
      req_valid = '0;
      rsp_ready = 1'b0;
      next_cyc();
      chk("bp3_sum", 32'(rsp_sum), 32'h03);
      chk("bp3_id",  32'(rsp_id),  32'd3);

      // Asynchronous reset while a response is stalled, mid-cycle.
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_vld",  32'(rsp_valid), 32'd0);
      chk("arst_sum",  32'(rsp_sum),   32'd0);
      chk("arst_id",   32'(rsp_id),    32'd0);
      chk("arst_busy", 32'(busy),      32'd0);
      next_cyc();
      rst_n = 1'b1;
      next_cyc();

      // Reset during EXEC abandons the operation and returns the pointer to 0.
      rsp_ready = 1'b1;
      req_valid = '0;
      set_req(1, 8'h10, 8'h20);
      next_cyc();
      req_valid = '0;
      chk("exec_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("exec_rst_busy", 32'(busy), 32'd0);
      next_cyc();
      rst_n = 1'b1;
      viol = 0;
      repeat (5) begin
         next_cyc();
         if (rsp_valid !== 1'b0 || busy !== 1'b0) viol++;
      end
      chk("exec_no_rsp", 32'(viol), 32'd0);
      set_req(0, 8'h03, 8'h04);
      set_req(1, 8'h10, 8'h20);
      #1;
      chk("exec_ptr0", 32'(req_ready), 32'h1);
      run_op("after_rst", 0, 8'h03, 8'h04, 8'h07, 1'b0);

      // Round robin from a fresh pointer.
      rst_n = 1'b0;
      next_cyc();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 8'(i), 8'h01);
      #1;
      viol = 0;
      for (int c = 0; c < 15; c++) begin
         if (!$onehot0(req_ready)) viol++;
         for (int i = 0; i < N; i++)
            if (req_ready[i]) begin
               gid.push_back(i);
               gcyc.push_back(c);
            end
         next_cyc();
      end
      chk("rr_onehot", 32'(viol), 32'd0);
      chk("rr_count",  32'(gid.size()), 32'd5);
      if (gid.size() == 5) begin
         chk("rr_order0", 32'(gid[0]), 32'd0);
         chk("rr_order1", 32'(gid[1]), 32'd1);
         chk("rr_order2", 32'(gid[2]), 32'd2);
         chk("rr_order3", 32'(gid[3]), 32'd3);
         chk("rr_order4", 32'(gid[4]), 32'd0);
         viol = 0;
         for (int k = 0; k < 4; k++) if (gcyc[k+1] - gcyc[k] != 3) viol++;
         chk("rr_spacing", 32'(viol), 32'd0);
      end
      drain();

      // Random soak with a one-deep scoreboard.
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      viol = 0;
      for (int c = 0; c < 6000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (c >= 5980) pend[i] = 1'b0;
            else if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               pa[i] = 8'($urandom_range(0, 255));
               pb[i] = 8'($urandom_range(0, 255));
            end else if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
            req_valid[i] = pend[i];
            req_a[8*i +: 8] = pa[i];
            req_b[8*i +: 8] = pb[i];
         end
         rsp_ready = (c >= 5980) || ($urandom_range(0, 9) < 7);
         @(negedge clk);
         acc = req_valid & req_ready;
         if (!$onehot0(req_ready) || (req_ready & ~req_valid) != '0) viol++;
         for (int i = 0; i < N; i++)
            if (acc[i]) begin
               q_id.push_back(i);
               q_s9.push_back(int'(pa[i]) + int'(pb[i]));
               pend[i] = 1'b0;
            end
         if (rsp_valid && rsp_ready) begin
            if (q_id.size() == 0) chk("soak_spurious", 32'd1, 32'd0);
            else begin
               e_id = q_id.pop_front();
               e_s9 = q_s9.pop_front();
               chk("soak_id",    32'(rsp_id),    32'(e_id));
               chk("soak_sum",   32'(rsp_sum),   32'(e_s9 & 8'hFF));
               chk("soak_carry", 32'(rsp_carry), 32'(e_s9 >> 8));
            end
         end
         next_cyc();
      end
      chk("soak_ready_legal", 32'(viol), 32'd0);
      chk("soak_drained", 32'(q_id.size()), 32'd0);
      n = 0;
      chk("soak_idle", 32'(busy), 32'(n));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
